// File: rtl/mem_arb_pkg.sv
// Shared types and width helpers for the multi-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arbState_e;

    function automatic int unsigned ramAddrWidth(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned grantWidth(input int unsigned numPorts);
        return (numPorts > 1) ? $clog2(numPorts) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_ram.sv
// Single-port synchronous RAM with registered read; reads and writes never coincide.
module mem_arb_ram #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin N-port front end sharing one single-port RAM; fixed 3-cycle access.
// Define MEM_ARB_BOUNDS_CHECK_EN to reject addresses >= DEPTH with err instead of aliasing.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned ADDR_W    = 24,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned DEPTH     = 1024
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS-1:0]        we,
    input  logic [NUM_PORTS*ADDR_W-1:0] addr,
    input  logic [NUM_PORTS*DATA_W-1:0] wdata,
    output logic [NUM_PORTS-1:0]        ack,
    output logic [DATA_W-1:0]           rdata,
    output logic                        err,
    output logic                        busy
);

    localparam int unsigned RAM_AW = ramAddrWidth(DEPTH);
    localparam int unsigned GNT_W  = grantWidth(NUM_PORTS);

    arbState_e state, nextState;

    logic [GNT_W-1:0]     grant;
    logic [GNT_W-1:0]     rrPtr;
    logic [GNT_W-1:0]     winIdx;
    logic                 winValid;
    int unsigned          cand;

    logic                 lWe;
    logic [ADDR_W-1:0]    lAddr;
    logic [DATA_W-1:0]    lWdata;

    logic                 outOfRange;
    logic                 ramEn;
    logic [DATA_W-1:0]    ramQ;
    logic [NUM_PORTS-1:0] ackReg;
    logic                 busyReg;

    // Round-robin search: first requester at or after rrPtr, wrapping.
    always_comb begin
        winValid = 1'b0;
        winIdx   = '0;
        cand     = 0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            cand = 32'(rrPtr) + i;
            if (cand >= NUM_PORTS) begin
                cand = cand - NUM_PORTS;
            end
            if (!winValid && req[cand[GNT_W-1:0]]) begin
                winValid = 1'b1;
                winIdx   = cand[GNT_W-1:0];
            end
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (winValid) nextState = ACCESS;
            ACCESS:  nextState = RESP;
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

`ifdef MEM_ARB_BOUNDS_CHECK_EN
    assign outOfRange = (lAddr >> RAM_AW) != '0;
`else
    assign outOfRange = 1'b0;
    if (ADDR_W > RAM_AW) begin : gAlias
        logic unusedHigh;
        assign unusedHigh = |lAddr[ADDR_W-1:RAM_AW];
    end
`endif

    assign ramEn = (state == ACCESS) && !outOfRange;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            grant   <= '0;
            rrPtr   <= '0;
            lWe     <= 1'b0;
            lAddr   <= '0;
            lWdata  <= '0;
            ackReg  <= '0;
            busyReg <= 1'b0;
        end else begin
            state   <= nextState;
            ackReg  <= (nextState == RESP) ? (NUM_PORTS'(1) << grant) : '0;
            busyReg <= (nextState != IDLE);
            if (state == IDLE && winValid) begin
                grant  <= winIdx;
                lWe    <= we[winIdx];
                lAddr  <= addr[32'(winIdx)*ADDR_W +: ADDR_W];
                lWdata <= wdata[32'(winIdx)*DATA_W +: DATA_W];
            end
            if (state == RESP) begin
                rrPtr <= (grant == GNT_W'(NUM_PORTS-1)) ? '0 : grant + 1'b1;
            end
        end
    end

`ifdef MEM_ARB_BOUNDS_CHECK_EN
    logic errReg;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            errReg <= 1'b0;
        end else begin
            errReg <= (nextState == RESP) && outOfRange;
        end
    end
    assign err = errReg;
`else
    assign err = 1'b0;
`endif

    mem_arb_ram #(
        .ADDR_W(RAM_AW),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) uRam (
        .clk  (CLK),
        .en   (ramEn),
        .we   (lWe),
        .addr (lAddr[RAM_AW-1:0]),
        .wdata(lWdata),
        .rdata(ramQ)
    );

    // Response data is selected only from registers (state, latched write data, RAM output register).
    always_comb begin
        rdata = '0;
        if (state == RESP && !outOfRange) begin
            rdata = lWe ? lWdata : ramQ;
        end
    end

    assign ack  = ackReg;
    assign busy = busyReg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int NP = 4;
    localparam int AW = 24;
    localparam int DW = 16;
    localparam int DP = 1024;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic [NP-1:0]    req = '0;
    logic [NP-1:0]    we = '0;
    logic [NP*AW-1:0] addr = '0;
    logic [NP*DW-1:0] wdata = '0;
    logic [NP-1:0]    ack;
    logic [DW-1:0]    rdata;
    logic             err;
    logic             busy;

    mem_port_arbiter #(
        .NUM_PORTS(NP),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .DEPTH    (DP)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .req  (req),
        .we   (we),
        .addr (addr),
        .wdata(wdata),
        .ack  (ack),
        .rdata(rdata),
        .err  (err),
        .busy (busy)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge CLK) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: one transaction at a time, response two edges after the grant.
    logic [DW-1:0] mMem [DP];
    bit            mMemKnown [DP];
    int            mLeft = 0;
    int            mPtr = 0;
    int            mPort = 0;
    int            mCand;
    bit            mFound;
    logic [AW-1:0] mAddr;
    int            mIdx;
    logic [DW-1:0] mData;
    bit            mKnown;
    bit            mErr;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mLeft = 0;
            mPtr  = 0;
        end else if (mLeft > 0) begin
            mLeft--;
            if (mLeft == 0) mPtr = (mPort + 1) % NP;
        end else if (req != 0) begin
            mFound = 0;
            for (int i = 0; i < NP; i++) begin
                mCand = (mPtr + i) % NP;
                if (!mFound && req[mCand]) begin
                    mFound = 1;
                    mPort  = mCand;
                end
            end
            mAddr = addr[mPort*AW +: AW];
            mIdx  = int'(mAddr % DP);
            mErr  = 0;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
            mErr  = (mAddr >= DP);
`endif
            if (mErr) begin
                mData  = '0;
                mKnown = 1;
            end else if (we[mPort]) begin
                mData           = wdata[mPort*DW +: DW];
                mMem[mIdx]      = mData;
                mMemKnown[mIdx] = 1;
                mKnown          = 1;
            end else begin
                mData  = mMem[mIdx];
                mKnown = mMemKnown[mIdx];
            end
            mLeft = 2;
        end
    end

    // Per-cycle comparison and response log.
    logic [NP-1:0] ackSeen = '0;
    int            ackPortLog[$];
    int            ackCycLog[$];
    logic [DW-1:0] ackDataLog[$];
    logic          ackErrLog[$];
    logic [NP-1:0] expAck;
    int            pIdx;

    always @(negedge CLK) begin
        if (RST_N) begin
            expAck = (mLeft == 1) ? NP'(1 << mPort) : '0;
            check("ack", 32'(ack), 32'(expAck));
            check("busy", 32'(busy), 32'(mLeft != 0));
            check("err", 32'(err), (mLeft == 1) ? 32'(mErr) : 32'(0));
            if (mLeft == 1 && mKnown) check("rdata", 32'(rdata), 32'(mData));
            ackSeen = ack;
            if (ack != 0) begin
                pIdx = 0;
                for (int i = 0; i < NP; i++) if (ack[i]) pIdx = i;
                ackPortLog.push_back(pIdx);
                ackCycLog.push_back(cyc);
                ackDataLog.push_back(rdata);
                ackErrLog.push_back(err);
            end
        end
    end

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } op_t;

    op_t portQ[NP][$];

    function automatic op_t mkOp(input logic w, input int a, input int d);
        op_t o;
        o.w = w;
        o.a = AW'(a);
        o.d = DW'(d);
        return o;
    endfunction

    task automatic clearLogs();
        ackPortLog.delete();
        ackCycLog.delete();
        ackDataLog.delete();
        ackErrLog.delete();
    endtask

    task automatic driveInputs();
        for (int p = 0; p < NP; p++) begin
            if (portQ[p].size() > 0) begin
                req[p]           = 1'b1;
                we[p]            = portQ[p][0].w;
                addr[p*AW +: AW] = portQ[p][0].a;
                wdata[p*DW +: DW] = portQ[p][0].d;
            end else begin
                req[p] = 1'b0;
            end
        end
    endtask

    function automatic bit allDone();
        for (int p = 0; p < NP; p++) if (portQ[p].size() > 0) return 0;
        return (mLeft == 0);
    endfunction

    // Requesters hold inputs until ack is seen, then pop; a non-empty queue keeps req high.
    task automatic runOps(input int budget);
        int n;
        n = 0;
        driveInputs();
        while (!allDone()) begin
            @(posedge CLK);
            #1;
            n++;
            for (int p = 0; p < NP; p++)
                if (ackSeen[p] && portQ[p].size() > 0) void'(portQ[p].pop_front());
            driveInputs();
            if (n > budget) begin
                tests++;
                fails++;
                $display("FAIL runOps_timeout: got %0d cycles required <= %0d", n, budget);
                for (int p = 0; p < NP; p++) portQ[p].delete();
                req = '0;
            end
        end
    endtask

    task automatic doReset();
        RST_N = 1'b0;
        req   = '0;
        for (int p = 0; p < NP; p++) portQ[p].delete();
        ackSeen = '0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    task automatic checkOrder(input string name, input int exp[$]);
        check({name, "_count"}, ackPortLog.size(), exp.size());
        if (ackPortLog.size() == exp.size())
            for (int i = 0; i < exp.size(); i++) check({name, "_port"}, ackPortLog[i], exp[i]);
    endtask

    int start;
    int expOrder[$];

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        @(negedge CLK);
        check("rst_ack", 32'(ack), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rdata", 32'(rdata), 0);
        check("rst_err", 32'(err), 0);
        @(posedge CLK);
        #1;

        // Single port: write then read back, port held across the first ack.
        clearLogs();
        start = cyc;
        portQ[0].push_back(mkOp(1, 5, 'hBEEF));
        portQ[0].push_back(mkOp(0, 5, 0));
        runOps(40);
        check("sp_count", ackPortLog.size(), 2);
        if (ackPortLog.size() == 2) begin
            check("sp_latency", ackCycLog[0] - start, 2);
            check("sp_echo", 32'(ackDataLog[0]), 'hBEEF);
            check("sp_read", 32'(ackDataLog[1]), 'hBEEF);
            check("sp_err", 32'(ackErrLog[1]), 0);
            check("sp_gap", ackCycLog[1] - ackCycLog[0], 3);
        end

        // Contention from a fresh pointer.
        doReset();
        clearLogs();
        for (int p = 0; p < NP; p++) portQ[p].push_back(mkOp(1, 10 + p, 'hA000 + p));
        portQ[0].push_back(mkOp(0, 10, 0));
        runOps(60);
        expOrder = '{0, 1, 2, 3, 0};
        checkOrder("cont", expOrder);
        if (ackCycLog.size() == 5) begin
            for (int i = 1; i < 5; i++) check("cont_gap", ackCycLog[i] - ackCycLog[i-1], 3);
            check("cont_read", 32'(ackDataLog[4]), 'hA000);
        end

        clearLogs();
        for (int a = 11; a <= 13; a++) portQ[2].push_back(mkOp(0, a, 0));
        runOps(40);
        if (ackDataLog.size() == 3)
            for (int i = 0; i < 3; i++) check("readback", 32'(ackDataLog[i]), 'hA001 + i);
        else check("readback_count", ackDataLog.size(), 3);

        // Pointer lands on 2 after port 1 is served; then ports 0 and 3 contend.
        portQ[1].push_back(mkOp(0, 11, 0));
        runOps(20);
        clearLogs();
        portQ[0].push_back(mkOp(0, 10, 0));
        portQ[3].push_back(mkOp(0, 13, 0));
        runOps(30);
        expOrder = '{3, 0};
        checkOrder("fair", expOrder);
        if (ackDataLog.size() == 2) begin
            check("fair_d3", 32'(ackDataLog[0]), 'hA003);
            check("fair_d0", 32'(ackDataLog[1]), 'hA000);
        end

        // Back-to-back on one port with a new address.
        clearLogs();
        portQ[1].push_back(mkOp(0, 12, 0));
        portQ[1].push_back(mkOp(1, 20, 'h5555));
        runOps(30);
        check("b2b_count", ackCycLog.size(), 2);
        if (ackCycLog.size() == 2) begin
            check("b2b_gap", ackCycLog[1] - ackCycLog[0], 3);
            check("b2b_d0", 32'(ackDataLog[0]), 'hA002);
            check("b2b_d1", 32'(ackDataLog[1]), 'h5555);
        end

        // Address just past DEPTH.
        clearLogs();
        portQ[0].push_back(mkOp(1, 0, 'h0A0A));
        portQ[0].push_back(mkOp(1, 'h000400, 'hDEAD));
        portQ[0].push_back(mkOp(0, 0, 0));
        runOps(40);
        check("bnd_count", ackDataLog.size(), 3);
        if (ackDataLog.size() == 3) begin
`ifdef MEM_ARB_BOUNDS_CHECK_EN
            check("bnd_err", 32'(ackErrLog[1]), 1);
            check("bnd_rdata", 32'(ackDataLog[1]), 0);
            check("bnd_ram0", 32'(ackDataLog[2]), 'h0A0A);
`else
            check("bnd_err", 32'(ackErrLog[1]), 0);
            check("bnd_rdata", 32'(ackDataLog[1]), 'hDEAD);
            check("bnd_ram0", 32'(ackDataLog[2]), 'hDEAD);
`endif
        end

        // Reset while in ACCESS abandons the transaction.
        req[2]           = 1'b1;
        we[2]            = 1'b0;
        addr[2*AW +: AW] = AW'(5);
        @(posedge CLK);
        #1;
        check("rm_busy_pre", 32'(busy), 1);
        RST_N = 1'b0;
        #1;
        check("rm_ack", 32'(ack), 0);
        check("rm_busy", 32'(busy), 0);
        req = '0;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        clearLogs();
        start = cyc;
        portQ[2].push_back(mkOp(0, 5, 0));
        runOps(20);
        check("rm_count", ackCycLog.size(), 1);
        if (ackCycLog.size() == 1) begin
            check("rm_latency", ackCycLog[0] - start, 2);
            check("rm_port", ackPortLog[0], 2);
            check("rm_data", 32'(ackDataLog[0]), 'hBEEF);
        end

        repeat (2) @(posedge CLK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Parametrised multi-port memory controller: N independent requesters share one on-chip single-port synchronous RAM through a request/acknowledge handshake with round-robin arbitration. It succeeds the single-port-A memory control path and sits between CPU/DMA/display-style requesters and the block RAM. Each access completes in a fixed 3-cycle sequence. Read data and the acknowledge are registered.

## Interface
Parameters:
- NUM_PORTS, 4, number of requesters (2..8)
- ADDR_W, 24, address width per port
- DATA_W, 16, data width
- DEPTH, 1024, RAM words (power of two, ≤ 2**ADDR_W)

Ports:
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous, active-low reset
- req  in  NUM_PORTS  per-port request, held until ack
- we  in  NUM_PORTS  per-port write enable (1 = write, 0 = read)
- addr  in  NUM_PORTS*ADDR_W  flattened addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
- wdata  in  NUM_PORTS*DATA_W  flattened write data, same packing
- ack  out  NUM_PORTS  one-hot, one-cycle completion pulse
- rdata  out  DATA_W  shared response data, valid while ack is nonzero
- err  out  1  access rejected; valid with ack (see Configuration)
- busy  out  1  controller not in IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req bit is high, select the winner by round-robin.
  - Search starts at rr_ptr and wraps modulo NUM_PORTS.
  - Latch the winner index, we, addr and wdata.
  - Go to ACCESS. Otherwise stay in IDLE.
- ACCESS:
  - Issue exactly one RAM operation at the latched address (low clog2(DEPTH) bits).
  - Write: RAM[a] ← wdata. Read: RAM output is registered.
  - Go to RESP.
- RESP:
  - ack[grant] = 1 for one cycle.
  - rdata = RAM read data on a read; the latched wdata on a write (write-through echo).
  - rr_ptr ← (grant+1) mod NUM_PORTS.
  - Return to IDLE.
- Requester rule:
  - Inputs must stay stable from req rise until ack is sampled.
  - Deassert req on the edge where ack is seen, or keep it high to issue a back-to-back request.
  - Changing inputs mid-transaction has no effect; they are latched in IDLE.
- Simultaneous requests: exactly one grant per transaction. With all ports requesting continuously, grants rotate 0,1,2,...,N-1,0.
- A req that drops before it is granted is simply never served. No error is raised.
- Reset mid-operation:
  - The transaction is abandoned and no ack is issued.
  - An in-progress RAM write may or may not have landed.
  - RAM contents are not cleared by reset.
- Reset values: state = IDLE, ack = 0, rdata = 0, err = 0, busy = 0, rr_ptr = 0, grant = 0.

## Timing
- Latency: req sampled high in IDLE at edge k → ack high during cycle k+2 → back in IDLE at edge k+3.
- Throughput: one access per 3 cycles. A held req is re-arbitrated at edge k+3.
- ack, rdata, err and busy are registered, with no combinational input-to-output path.
- busy is high during ACCESS and RESP.

## Configuration
- MEM_ARB_BOUNDS_CHECK_EN defined:
  - If the latched addr ≥ DEPTH, the RAM is not accessed (no write, no read).
  - The response still occurs with rdata = 0, err = 1 and ack pulsed.
  - rr_ptr advances as normal.
- Not defined:
  - err is tied to 0.
  - Upper address bits are ignored, so addresses alias modulo DEPTH.

## Structure
- mem_arb_pkg holds:
  - the state enum (IDLE/ACCESS/RESP)
  - localparam helpers: ram address width = clog2(DEPTH), grant index width = clog2(NUM_PORTS)
- Sub-module mem_arb_ram: single-port synchronous RAM with registered read and write-first-free semantics (reads and writes never coincide).
- Arbiter, FSM and response registers live in the top module.

## Test plan
- Reset: assert RST_N=0 mid-ACCESS → ack=0, busy=0 and state IDLE immediately. Release, then read any address → completes in 3 cycles.
- Single port: port 0 writes 0xBEEF to address 5, then reads address 5 → write ack echoes 0xBEEF; read ack at k+2 returns 0xBEEF, err=0.
- Contention: all 4 ports hold req with distinct writes to addresses 10..13 → acks arrive in order ports 0,1,2,3,0, spaced 3 cycles apart; read-back matches.
- Fairness after grant: rr_ptr=2 and ports 0 and 3 request → port 3 is granted first, then port 0.
- Bounds (macro on): write addr 0x000400 with DEPTH=1024 → err=1, rdata=0, RAM[0] unchanged. Macro off: the same write lands at RAM[0] and err=0.
- Back-to-back: port 1 holds req across ack with a new address → second ack arrives exactly 3 cycles after the first.
